pulse_stretcher: RTL
====================

# pulse_stretcher

Converts single-cycle strobes on `pulse_in` into a clean level held for a fixed number of clock cycles, followed by a mandatory low gap before the next level. It is the companion of the team's level-to-pulse converter: edge-detected strobes from control logic feed back in here to drive level-sensitive consumers such as LEDs, enables and slow peripherals. It is a Moore FSM with a down-counter, a one-deep pending slot, drop reporting and an event counter.

## Interface
- `HOLD_CYCLES`, default 8: cycles `level_out` stays high per stretch; must be ≥1.
- `GAP_CYCLES`, default 2: minimum low cycles after each stretch; 0 is legal.
- `CNT_W`, default 8: width of `stretch_cnt`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `pulse_in` input, 1 bit: strobe, sampled every rising edge.
- `level_out` output, 1 bit: stretched level, registered.
- `busy` output, 1 bit: high in HOLD or GAP.
- `dropped` output, 1 bit: one-cycle strobe when an input pulse is discarded.
- `stretch_cnt` output, `CNT_W` bits: number of HOLD entries; wraps modulo 2^CNT_W.

## Operation
- States are IDLE, HOLD and GAP. `level_out` = (state==HOLD). `busy` = (state!=IDLE).
- Internal down-counter `cnt` is sized to hold max(HOLD_CYCLES, GAP_CYCLES)−1. There is also one `pending` bit.
- IDLE:
  - pulse → HOLD, load cnt=HOLD_CYCLES−1, stretch_cnt+1.
  - no pulse → stay IDLE.
- HOLD:
  - If cnt==0 and no accepted retrigger: GAP_CYCLES>0 → GAP with cnt=GAP_CYCLES−1; GAP_CYCLES==0 → IDLE.
  - Otherwise decrement cnt.
  - A pulse in HOLD is handled per the Configuration section.
- GAP:
  - A pulse with pending==0 sets pending.
  - A pulse with pending==1 is dropped.
  - When cnt==0: if pending or a pulse this cycle → HOLD (reload cnt, stretch_cnt+1, clear pending); else → IDLE.
  - Otherwise decrement cnt.
- `dropped` is registered and asserts the cycle after the discarded pulse was sampled.
- Back-to-back pulses in IDLE: the first one is accepted. The second lands in HOLD and follows the HOLD rule.
- The reset asserted at any time forces the outputs below immediately, mid-stretch included, with no gap enforced after release.
- Reset values: state=IDLE, cnt=0, pending=0, `level_out`=0, `busy`=0, `dropped`=0, `stretch_cnt`=0.

## Timing
- A pulse sampled at edge E raises `level_out` in the cycle after E. It stays high exactly HOLD_CYCLES cycles.
- The gap is exactly GAP_CYCLES low cycles, with `busy` high.
- When a pulse is pending at gap end, `level_out` rises in the first cycle after the gap. No extra idle cycle is inserted.
- With retrigger enabled, the last high cycle is HOLD_CYCLES cycles after the most recent accepted retrigger edge.
- `stretch_cnt` updates on the same edge that enters HOLD.
- No combinational path exists from `pulse_in` to any output.

## Configuration
- `PULSE_STRETCHER_RETRIGGER_EN` defined: a pulse in HOLD (including cnt==0) reloads cnt=HOLD_CYCLES−1 and extends the level. It does not increment `stretch_cnt` and does not assert `dropped`.
- Not defined: a pulse in HOLD is discarded and asserts `dropped`. The level length is always exactly HOLD_CYCLES.

## Structure
- Package `pulse_stretcher_pkg`:
  - state encoding localparams: IDLE=2'b00, HOLD=2'b01, GAP=2'b10;
  - a function computing the counter width from HOLD_CYCLES/GAP_CYCLES.
- One sub-module, `stretch_down_counter`:
  - loadable down-counter with load, load value, decrement enable and a `zero` flag;
  - asynchronous active-low reset.
- The top level holds the FSM, the pending bit, the drop strobe and the event counter.

## Test plan
All scenarios use HOLD_CYCLES=4 and GAP_CYCLES=2.
- Single pulse at cycle 10 → `level_out` high cycles 11–14, `busy` high 11–16, `stretch_cnt`=1.
- Pulse at 10 and pulse at 15 (in GAP) → second stretch high 17–20, with no idle cycle between; `stretch_cnt`=2, `dropped` never asserted.
- Pulses at 10, 15, 16 → pulse 16 dropped and `dropped` high at 17; stretch 17–20; `stretch_cnt`=2.
- Pulses at 10 and 12:
  - with `PULSE_STRETCHER_RETRIGGER_EN`, high 11–16 and `stretch_cnt`=1;
  - without it, high 11–14 and `dropped` high at 13.
- `reset` asserted asynchronously mid-cycle at 12 during HOLD → `level_out`, `busy`, `stretch_cnt` immediately 0. A pulse at the first edge after release starts a fresh 4-cycle stretch.
- GAP_CYCLES=0 with a pulse every 5 cycles → continuous 4-high/1-low pattern, and `stretch_cnt` wraps from 255 to 0 with CNT_W=8.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg
//   Shared definitions for the pulse stretcher: FSM state encoding and the
//   helper that sizes the internal down-counter from the hold/gap lengths.
package pulse_stretcher_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_HOLD = HOLD,
        S_GAP  = GAP
    } state_e;

    // Width needed to hold max(hold, gap) - 1; never less than one bit.
    function automatic int calc_cnt_w(input int hold, input int gap);
        int m;
        m = ((hold > gap) ? hold : gap) - 1;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/stretch_down_counter.sv
// stretch_down_counter
//   Loadable down-counter used to time the HOLD and GAP phases.
//   Ports:
//     clk      - rising-edge clock
//     reset    - asynchronous active-low reset (count returns to 0)
//     load     - load load_val this edge (takes priority over dec)
//     load_val - value to load
//     dec      - decrement by one this edge
//     zero     - count is currently zero
module stretch_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle strobes into a level held HOLD_CYCLES cycles,
//   followed by at least GAP_CYCLES low cycles. One strobe arriving during
//   the gap is remembered and starts the next stretch right after the gap;
//   further strobes are discarded and reported on 'dropped'.
//   Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN -- when defined, a
//   strobe during HOLD restarts the hold time instead of being discarded.
//   Ports:
//     clk         - rising-edge clock
//     reset       - asynchronous active-low reset
//     pulse_in    - strobe, sampled every rising edge
//     level_out   - stretched level (registered, high in HOLD)
//     busy        - high in HOLD or GAP (registered)
//     dropped     - one-cycle strobe, the cycle after a discarded pulse
//     stretch_cnt - number of HOLD entries, wraps
//     state_dbg   - current FSM state (debug observation)
//   All outputs come from flops; pulse_in reaches none of them combinationally.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic             level_out,
    output logic             busy,
    output logic             dropped,
    output logic [CNT_W-1:0] stretch_cnt,
    output logic [1:0]       state_dbg
);

    localparam int CW = calc_cnt_w(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    // With no gap the GAP state is never entered; load value is unused then.
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    state_e          state_q, state_nxt;
    logic            pending_q, pending_nxt;
    logic            drop_nxt;
    logic            inc;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]   cnt_load_val;
    logic            level_q, busy_q, dropped_q;
    logic [CNT_W-1:0] stretch_q;

    stretch_down_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt    = state_q;
        pending_nxt  = pending_q;
        drop_nxt     = 1'b0;
        inc          = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = HOLD_LOAD;
        cnt_dec      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pulse_in) begin
                    state_nxt = S_HOLD;
                    cnt_load  = 1'b1;
                    inc       = 1'b1;
                end
            end
            S_HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                if (pulse_in) begin
                    // Restart the hold time, even on its final cycle.
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
`else
                if (pulse_in) begin
                    drop_nxt = 1'b1;
                end
                if (cnt_zero) begin
`endif
                    if (GAP_CYCLES > 0) begin
                        state_nxt    = S_GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_GAP: begin
                if (pulse_in && pending_q) begin
                    drop_nxt = 1'b1;
                end
                if (cnt_zero) begin
                    // A strobe on the last gap cycle goes straight to HOLD.
                    if (pending_q || pulse_in) begin
                        state_nxt   = S_HOLD;
                        cnt_load    = 1'b1;
                        inc         = 1'b1;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                    if (pulse_in && !pending_q) begin
                        pending_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
            level_q   <= 1'b0;
            busy_q    <= 1'b0;
            stretch_q <= '0;
        end else begin
            state_q   <= state_nxt;
            pending_q <= pending_nxt;
            dropped_q <= drop_nxt;
            level_q   <= (state_nxt == S_HOLD);
            busy_q    <= (state_nxt != S_IDLE);
            if (inc) begin
                stretch_q <= stretch_q + 1'b1;
            end
        end
    end

    assign level_out   = level_q;
    assign busy        = busy_q;
    assign dropped     = dropped_q;
    assign stretch_cnt = stretch_q;
    assign state_dbg   = state_q;

endmodule
